// File: rtl/aro_pkg.sv
// rtl/aro_pkg.sv - shared types and sizing helpers for the adaptive rank-order window controller
package aro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int levels_of(input int n);
    return (n - 3) / 2;
  endfunction

  function automatic int win_size(input int l);
    return 2 * l + 3;
  endfunction

  function automatic int level_w(input int n);
    return $clog2(levels_of(n) + 1);
  endfunction

  localparam int N_DEF   = 7;
  localparam int LEVEL_W = level_w(N_DEF);

endpackage

// File: rtl/adder_ladder.sv
// rtl/adder_ladder.sv - centre-sample rank over the window selected by a thermometer level mask
module adder_ladder
  import aro_pkg::*;
#(
  parameter int N         = 7,
  parameter int rank_bits = $clog2(N + 1)
) (
  input  logic [N-2:0]           in,
  input  logic [levels_of(N)-1:0] k,
  output logic [rank_bits-1:0]   out
);

  // The innermost pair is always counted; each outer pair is gated by its level bit.
  always_comb begin
    out = rank_bits'(1) + rank_bits'(in[0]) + rank_bits'(in[1]);
    for (int j = 2; j < N - 1; j++) begin
      if (k[(j-2)/2]) begin
        out = out + rank_bits'(in[j]);
      end
    end
  end

endmodule

// File: rtl/aro_window_ctrl.sv
// rtl/aro_window_ctrl.sv - grows the filter window until the centre sample stops being an extreme
module aro_window_ctrl
  import aro_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int rank_bits  = $clog2(N + 1),
  parameter int LEVELS     = levels_of(N),
  parameter int level_bits = level_w(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-2:0]          in_cmp,
  input  logic [level_bits-1:0] cfg_max_level,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [rank_bits-1:0]  out_rank,
  output logic [level_bits-1:0] out_level,
  output logic                  out_impulse
);

  state_t                state_q, state_d;
  logic [N-2:0]          cmp_q, cmp_d;
  logic [level_bits-1:0] max_q, max_d;
  logic [level_bits-1:0] level_q, level_d;
  logic [LEVELS-1:0]     k_q, k_d;
  logic                  in_ready_d, out_valid_d, impulse_d;
  logic [rank_bits-1:0]  rank, rank_d;
  logic [level_bits-1:0] out_level_d;
  logic [level_bits-1:0] cfg_clamped;
  logic                  extreme;

  adder_ladder #(
    .N         (N),
    .rank_bits (rank_bits)
  ) u_ladder (
    .in  (cmp_q),
    .k   (k_q),
    .out (rank)
  );

  assign cfg_clamped = (int'(cfg_max_level) > LEVELS) ? level_bits'(LEVELS) : cfg_max_level;
  assign extreme     = (rank == rank_bits'(1)) ||
                       (rank == rank_bits'(win_size(int'(level_q))));

  always_comb begin
    state_d     = state_q;
    cmp_d       = cmp_q;
    max_d       = max_q;
    level_d     = level_q;
    k_d         = k_q;
    rank_d      = out_rank;
    out_level_d = out_level;
    impulse_d   = out_impulse;
    case (state_q)
      IDLE: begin
        if (in_ready && in_valid) begin
          cmp_d   = in_cmp;
          max_d   = cfg_clamped;
          level_d = '0;
          k_d     = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (!extreme || (level_q == max_q)) begin
          rank_d      = rank;
          out_level_d = level_q;
          impulse_d   = extreme;
          state_d     = DONE;
        end else begin
          level_d = level_q + 1'b1;
          k_d     = (k_q << 1) | LEVELS'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered decodes of the next state, so out_ready never reaches in_ready combinationally.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmp_q       <= '0;
      max_q       <= '0;
      level_q     <= '0;
      k_q         <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_rank    <= '0;
      out_level   <= '0;
      out_impulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmp_q       <= cmp_d;
      max_q       <= max_d;
      level_q     <= level_d;
      k_q         <= k_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      out_rank    <= rank_d;
      out_level   <= out_level_d;
      out_impulse <= impulse_d;
    end
  end

endmodule

// File: tb/tb_aro_window_ctrl.sv
// tb/tb_aro_window_ctrl.sv - directed scoreboard bench for aro_window_ctrl
module tb_aro_window_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_cmp;
  logic [1:0] cfg_max_level;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_rank;
  logic [1:0] out_level;
  logic       out_impulse;

  typedef struct {
    logic [2:0] rank;
    logic [1:0] level;
    logic       imp;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  aro_window_ctrl #(.N(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_cmp        (in_cmp),
    .cfg_max_level (cfg_max_level),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rank      (out_rank),
    .out_level     (out_level),
    .out_impulse   (out_impulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [2:0] r, input logic [1:0] l, input logic i, input int lat);
    exp_t e;
    e.rank  = r;
    e.level = l;
    e.imp   = i;
    e.lat   = lat;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [5:0] cmp, input logic [1:0] cfg, input exp_t e);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid      = 1'b1;
    in_cmp        = cmp;
    cfg_max_level = cfg;
    @(posedge clk); #1;
    in_valid      = 1'b0;
    in_cmp        = ~cmp;
    cfg_max_level = ~cfg;
    sb.push_back(e);
  endtask

  task automatic wait_out(input string tag);
    int   c = 0;
    exp_t e;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!out_valid && c < 20);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(c), 32'(e.lat));
      check({tag, "_rank"},    32'(out_rank), 32'(e.rank));
      check({tag, "_level"},   32'(out_level), 32'(e.level));
      check({tag, "_impulse"}, 32'(out_impulse), 32'(e.imp));
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_cmp        = '0;
    cfg_max_level = '0;
    out_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rank",      32'(out_rank), 32'd0);
    check("rst_level",     32'(out_level), 32'd0);
    check("rst_impulse",   32'(out_impulse), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_edge_in_ready", 32'(in_ready), 32'd1);

    send(6'b000001, 2'd2, mk(3'd2, 2'd0, 1'b0, 1));
    wait_out("t1");
    drain("t1");

    send(6'b001011, 2'd2, mk(3'd4, 2'd1, 1'b0, 2));
    wait_out("t2");
    drain("t2");

    send(6'b000000, 2'd2, mk(3'd1, 2'd2, 1'b1, 3));
    wait_out("t3");
    drain("t3");

    send(6'b111111, 2'd0, mk(3'd3, 2'd0, 1'b1, 1));
    wait_out("t4");
    drain("t4");

    send(6'b111111, 2'd3, mk(3'd7, 2'd2, 1'b1, 3));
    wait_out("t5");
    drain("t5");

    out_ready = 1'b0;
    send(6'b000001, 2'd2, mk(3'd2, 2'd0, 1'b0, 1));
    wait_out("bp");
    in_valid      = 1'b1;
    in_cmp        = 6'b111111;
    cfg_max_level = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid",    32'(out_valid), 32'd1);
      check("bp_hold_rank",     32'(out_rank), 32'd2);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain("bp");
    send(6'b000011, 2'd2, mk(3'd3, 2'd1, 1'b0, 2));
    wait_out("bp_next");
    drain("bp_next");

    send(6'b000000, 2'd2, mk(3'd1, 2'd2, 1'b1, 3));
    @(posedge clk); #1;
    check("mid_eval_no_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready",  32'(in_ready), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_rank",      32'(out_rank), 32'd0);
    check("async_rst_level",     32'(out_level), 32'd0);
    check("async_rst_impulse",   32'(out_impulse), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready",  32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_stale_valid", 32'(out_valid), 32'd0);

    send(6'b001011, 2'd1, mk(3'd4, 2'd1, 1'b0, 2));
    wait_out("t_after_rst");
    drain("t_after_rst");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aro_window_ctrl.md
# aro_window_ctrl

Adaptive window controller for the rank-order filter datapath. Accepts one set of N-1 comparator bits per sample, where each bit means the centre sample is greater than that neighbour. It grows the active window level by level, using the adder ladder to compute the centre sample's rank at each level, and stops at the first level where the centre is not an extreme, or at the configured maximum. It returns the final rank, the level reached and an impulse flag downstream over a valid/ready pair.

## Interface
- N, 7, window size; odd, ≥5
- rank_bits, $clog2(N+1), rank width
- LEVELS, (N-3)/2, number of expandable levels; the k mask width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  controller can accept
- in_cmp  in  N-1  comparator bits; bits [1:0] are the innermost pair, bits [2i+3:2i+2] are enabled by level i+1
- cfg_max_level  in  $clog2(LEVELS+1)  maximum level, sampled at accept; values above LEVELS are clamped to LEVELS
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_rank  out  rank_bits  rank of centre in the final window, 1..2L+3
- out_level  out  $clog2(LEVELS+1)  final level L
- out_impulse  out  1  centre was extreme at the final level

## Operation
- Level L: window = 2L+3 samples; ladder mask k = thermometer with L ones (k[i] = i < L).
- Ladder rank = 1 + in_cmp[0] + in_cmp[1] + Σ in_cmp[j] for j ≥ 2 with k[(j-2)/2] = 1.
- Extreme at L: rank == 1 or rank == 2L+3.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch in_cmp into cmp_q, latch the clamped cfg_max_level into max_q, set level_q=0 and k_q=0, go to EVAL.
  - EVAL: the ladder sees cmp_q and k_q.
    - If not extreme: latch rank into out_rank, L into out_level, set out_impulse=0, go to DONE.
    - Else if level_q == max_q: latch the same fields with out_impulse=1, go to DONE.
    - Else: level_q+1, k_q = {k_q[LEVELS-2:0],1}, stay in EVAL.
  - DONE: out_valid=1, outputs held stable. On out_ready go to IDLE.
- in_ready is asserted only in IDLE; in_valid in any other state is ignored and not buffered.
- Rank arithmetic is unsigned, rank_bits wide, and cannot overflow because the maximum is N < 2^rank_bits.
- A combinational path from out_ready to in_ready is forbidden; at least one IDLE cycle separates consecutive samples.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, out_valid=0, out_rank=0, out_level=0, out_impulse=0; state=IDLE, level_q=0, k_q=0.
- in_ready rises on the first clk edge after rst_n deasserts.
- Latency: with the accept on edge t0 and m = levels evaluated (1..LEVELS+1), out_valid is high from edge t0+m.
- out_valid holds until the edge where out_ready=1; it falls on that edge and in_ready rises on the same edge.
- Throughput: one sample per m+2 cycles with out_ready held high.
- rst_n low mid-EVAL or mid-DONE aborts immediately: the in-flight sample is discarded and no out_valid pulse is emitted.
- Accept and cfg_max_level sampling occur on the same edge; cfg_max_level changes afterwards have no effect on the sample in flight.

## Structure
- Shared package aro_pkg holds:
  - state enum {IDLE, EVAL, DONE};
  - functions levels_of(N) = (N-3)/2 and win_size(L) = 2L+3;
  - the width constant for level fields.
- One sub-module: adder_ladder (N, rank_bits), instantiated combinationally, with in=cmp_q, k=k_q, out giving the rank. There is no other hierarchy.

## Test plan
- N=7, cfg=2, in_cmp=6'b000001 → accept at t0; out_valid at t0+1 with rank=2, level=0, impulse=0.
- N=7, cfg=2, in_cmp=6'b001011 → level 0 rank=3 (extreme), level 1 rank=4 of 5 → out_valid at t0+2 with rank=4, level=1, impulse=0.
- N=7, cfg=2, in_cmp=6'b000000 → rank=1 at all levels → out_valid at t0+3 with rank=1, level=2, impulse=1.
- N=7, in_cmp=6'b111111: cfg=0 → out_valid at t0+1 with rank=3, level=0, impulse=1; cfg=3 (clamped to 2) → rank=7, level=2, impulse=1 at t0+3.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, a second in_valid is ignored; out_ready=1 → out_valid falls and in_ready rises on the same edge, then the next sample is accepted.
- Reset: assert rst_n low during EVAL → all outputs 0 asynchronously; after release, in_ready=1 one edge later and no stale out_valid appears.
